// File: rtl/res_arb_pkg.sv
// Shared constants and helpers for the result-RAM round-robin arbiter.
package res_arb_pkg;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 8;
    localparam int READ_LAT = 2;

    // Requester index; wide enough for up to four requesters.
    typedef logic [1:0] req_idx_t;

    // Next index in round-robin order, wrapping at nreq.
    function automatic req_idx_t next_idx(input req_idx_t idx, input int nreq);
        return (int'(idx) == nreq - 1) ? req_idx_t'(0) : req_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/res_ram_arb_rr_pick.sv
// Combinational round-robin priority picker: the first requester at or
// after rr (modulo NREQ) wins. Produces a one-hot grant and its index.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      rr,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      idx
);
    import res_arb_pkg::*;

    // Scan priority slots rr, rr+1, ... and grant the first active request.
    always_comb begin
        logic found;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && ((int'(rr) + k) % NREQ == i)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = req_idx_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/res_ram_arb.sv
// Round-robin arbiter sharing the single-port result RAM between NREQ
// requesters. One command per cycle is registered onto the RAM pins; read
// data returns to its owner two cycles after the grant.
// Optional feature: define RES_ARB_LOCK_EN to add the per-requester lock
// input that pins the grant to one requester for a burst.
module res_ram_arb #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = res_arb_pkg::ADDR_W,
    parameter int DATA_W = res_arb_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef RES_ARB_LOCK_EN
    input  logic [NREQ-1:0]          lock,
`endif
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     res_rd,
    output logic                     res_wr,
    output logic [ADDR_W-1:0]        res_addr,
    output logic [DATA_W-1:0]        res_do,
    input  logic [DATA_W-1:0]        res_di
);
    import res_arb_pkg::*;

    req_idx_t          rr;
    req_idx_t          pick_idx;
    req_idx_t          rd_owner;
    logic [NREQ-1:0]   elig;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NREQ-1:0]   rvalid_n;

`ifdef RES_ARB_LOCK_EN
    logic     locked;
    req_idx_t lock_idx;
    logic     lock_req;
    logic     lock_gnt_bit;
    logic     lock_drop;

    // While a lock is active only its holder is eligible; track its request and lock bits.
    always_comb begin
        elig         = locked ? (req & (NREQ'(1) << lock_idx)) : req;
        lock_req     = 1'b0;
        lock_gnt_bit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (lock_idx == req_idx_t'(i)) lock_req = req[i];
            if (gnt[i])                    lock_gnt_bit = lock[i];
        end
        lock_drop = locked && (!lock_req || (any_gnt && !lock_gnt_bit));
    end
`else
    assign elig = req;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (elig),
        .rr  (rr),
        .gnt (gnt),
        .idx (pick_idx)
    );

    assign any_gnt = |gnt;

    // One-hot mux of the granted requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RES_ARB_LOCK_EN
    // Advance rr past each grant; hold it frozen while a lock is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr       <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (locked) begin
            if (lock_drop) begin
                locked <= 1'b0;
                rr     <= next_idx(lock_idx, NREQ);
            end
        end else if (any_gnt) begin
            rr <= next_idx(pick_idx, NREQ);
            if (lock_gnt_bit) begin
                locked   <= 1'b1;
                lock_idx <= pick_idx;
            end
        end
    end
`else
    // Advance rr past each grant; hold it when nothing is granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) rr <= '0;
        else if (any_gnt) rr <= next_idx(pick_idx, NREQ);
    end
`endif

    // Register the granted command onto the RAM pins; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_rd   <= 1'b0;
            res_wr   <= 1'b0;
            res_addr <= '0;
            res_do   <= '0;
            rd_owner <= '0;
        end else begin
            res_rd <= any_gnt & ~sel_we;
            res_wr <= any_gnt &  sel_we;
            if (any_gnt) begin
                res_addr <= sel_addr;
                res_do   <= sel_wdata;
                rd_owner <= pick_idx;
            end
        end
    end

    // Decode the owner of the read currently on the RAM pins.
    always_comb begin
        rvalid_n = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (res_rd && rd_owner == req_idx_t'(i)) rvalid_n[i] = 1'b1;
        end
    end

    // Capture RAM read data and pulse rvalid for the owning requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rvalid_n;
            if (res_rd) rdata <= res_di;
        end
    end

endmodule

// File: tb/tb_res_ram_arb.sv
// Self-checking bench for res_ram_arb: directed cases plus randomized
// traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_res_ram_arb;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ-1:0]        lock;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   res_rd;
    logic                   res_wr;
    logic [ADDR_W-1:0]      res_addr;
    logic [DATA_W-1:0]      res_do;
    logic [DATA_W-1:0]      res_di;

    res_ram_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
`ifdef RES_ARB_LOCK_EN
        .lock     (lock),
`endif
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .res_rd   (res_rd),
        .res_wr   (res_wr),
        .res_addr (res_addr),
        .res_do   (res_do),
        .res_di   (res_di)
    );

    always #5 clk = ~clk;

    // Result RAM: reads captured on the falling edge, writes commit on the rising edge.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(negedge clk) if (res_rd) res_di <= ram[res_addr];
    always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

    // Reference model: memory contents in grant order, rr pointer, lock holder, read returns.
    typedef struct {
        int                due;
        int                idx;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    rd_exp_t           rq[$];
    int                m_rr;
    int                m_lock;
    logic              exp_rd, exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_do;
    int                cyc;
    int                last_g;
    int                errors;
    int                checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick();
        if (m_lock >= 0) return req[m_lock] ? m_lock : -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_rr + k) % NREQ;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_advance(input int g);
        if (m_lock >= 0) begin
            if (!req[m_lock] || (g == m_lock && !lock[m_lock])) begin
                m_rr   = (m_lock + 1) % NREQ;
                m_lock = -1;
            end
        end else if (g >= 0) begin
            m_rr = (g + 1) % NREQ;
            if (lock[g]) m_lock = g;
        end
    endfunction

    task automatic set_cmd(input int i, input logic r, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i] = r;
        we[i]  = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // One clock cycle: entered at posedge+1 with inputs applied, leaves at the next posedge+1.
    task automatic cycle();
        int                g;
        logic              rst_now;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        rd_exp_t           e;
        #1;
        g      = model_pick();
        last_g = g;
        check("gnt", 32'(gnt), (g >= 0) ? (32'(1) << g) : 32'd0);
        rst_now = reset;
        if (rst_now) begin
            m_rr = 0; m_lock = -1; rq.delete();
            exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_do = '0;
        end else begin
            if (g >= 0) begin
                a = addr[g*ADDR_W +: ADDR_W];
                d = wdata[g*DATA_W +: DATA_W];
                exp_addr = a;
                exp_do   = d;
                exp_wr   = we[g];
                exp_rd   = !we[g];
                if (we[g]) ref_mem[a] = d;
                else begin
                    e.due = cyc + 2; e.idx = g; e.data = ref_mem[a];
                    rq.push_back(e);
                end
            end else begin
                exp_rd = 1'b0;
                exp_wr = 1'b0;
            end
            model_advance(g);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("res_rd", 32'(res_rd), 32'(exp_rd));
        check("res_wr", 32'(res_wr), 32'(exp_wr));
        check("res_addr", 32'(res_addr), 32'(exp_addr));
        check("res_do", 32'(res_do), 32'(exp_do));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rvalid", 32'(rvalid), 32'(1) << rq[0].idx);
            check("rdata", 32'(rdata), 32'(rq[0].data));
            void'(rq.pop_front());
        end else begin
            check("rvalid_idle", 32'(rvalid), 32'd0);
        end
        if (rst_now) check("rdata_rst", 32'(rdata), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; we = '0; lock = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int w, r, iter;
        errors = 0; checks = 0; cyc = 0; last_g = -1;
        m_rr = 0; m_lock = -1;
        reset = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = DATA_W'(i * 7 + 3);
            ref_mem[i] = DATA_W'(i * 7 + 3);
        end
        @(posedge clk);
        #1;
        do_reset();
        check("rst_res_addr", 32'(res_addr), 32'd0);

        // Write then read the same address from requester 0.
        set_cmd(0, 1'b1, 1'b1, 14'h0081, 8'h05);
        cycle();
        check("t1_gnt_w", 32'(last_g), 32'd0);
        check("t1_res_wr", 32'(res_wr), 32'd1);
        set_cmd(0, 1'b1, 1'b0, 14'h0081, 8'h00);
        cycle();
        check("t1_gnt_r", 32'(last_g), 32'd0);
        check("t1_res_rd", 32'(res_rd), 32'd1);
        req = '0;
        cycle();
        check("t1_rvalid", 32'(rvalid), 32'd1);
        check("t1_rdata", 32'(rdata), 32'h05);
        cycle();

        // Two requesters reading distinct addresses must alternate.
        do_reset();
        set_cmd(0, 1'b1, 1'b0, 14'h0100, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 14'h0200, 8'h00);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t2_alt", 32'(last_g), 32'(k % 2));
        end
        req = '0;
        repeat (3) cycle();

        // Requester 1 alone for three grants, then requester 0 joins and wins.
        do_reset();
        set_cmd(1, 1'b1, 1'b0, 14'h0010, 8'h00);
        repeat (3) begin
            cycle();
            check("t3_solo", 32'(last_g), 32'd1);
        end
        set_cmd(0, 1'b1, 1'b0, 14'h0011, 8'h00);
        cycle();
        check("t3_join", 32'(last_g), 32'd0);
        req = '0;
        repeat (3) cycle();

        // Reset in the cycle after a read grant drops the pending return.
        do_reset();
        set_cmd(0, 1'b1, 1'b0, 14'h0081, 8'h00);
        cycle();
        req = '0; reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t4_res_rd", 32'(res_rd), 32'd0);
        check("t4_res_wr", 32'(res_wr), 32'd0);
        check("t4_rvalid", 32'(rvalid), 32'd0);
        cycle();
        check("t4_rvalid2", 32'(rvalid), 32'd0);
        check("t4_rdata", 32'(rdata), 32'd0);
        set_cmd(0, 1'b1, 1'b0, 14'h0001, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 14'h0002, 8'h00);
        cycle();
        check("t4_rr0", 32'(last_g), 32'd0);
        req = '0;
        repeat (3) cycle();

`ifdef RES_ARB_LOCK_EN
        // Requester 0 locks for a four-write burst while requester 1 waits.
        do_reset();
        set_cmd(1, 1'b1, 1'b0, 14'h0030, 8'h00);
        for (int k = 0; k < 4; k++) begin
            set_cmd(0, 1'b1, 1'b1, ADDR_W'(14'h0020 + k), DATA_W'(k));
            lock[0] = (k < 3);
            cycle();
            check("lk_burst", 32'(last_g), 32'd0);
        end
        lock = '0;
        set_cmd(0, 1'b1, 1'b1, 14'h0024, 8'h44);
        cycle();
        check("lk_after", 32'(last_g), 32'd1);
        req = '0;
        repeat (3) cycle();
`endif

        // Randomized traffic; each requester holds its command until granted.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || last_g == i) begin
                    set_cmd(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                            ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7)),
                            DATA_W'($urandom));
`ifdef RES_ARB_LOCK_EN
                    lock[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end
            cycle();
        end
        req = '0; lock = '0;
        repeat (3) cycle();

        // Full sweep: requester 0 writes every address, requester 1 reads each back.
        do_reset();
        w = 0; r = 0; iter = 0;
        while (r < DEPTH && iter < 40000) begin
            set_cmd(0, (w < DEPTH), 1'b1, ADDR_W'(w), DATA_W'(w));
            set_cmd(1, (r < w), 1'b0, ADDR_W'(r), 8'h00);
            cycle();
            if (last_g == 0) w++;
            else if (last_g == 1) r++;
            iter++;
        end
        req = '0;
        repeat (4) cycle();
        check("sweep_writes", 32'(w), 32'(DEPTH));
        check("sweep_reads", 32'(r), 32'(DEPTH));
        check("sweep_drained", 32'(rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
